// File: rtl/mp64_icache_pkg.sv
// Shared constants for the MP64 instruction cache: geometry and system-bus size encodings.
package mp64_icache_pkg;

  localparam int LINES  = 256;
  localparam int LINE_B = 16;
  localparam int TAG_W  = 52;
  localparam int IDX_W  = 8;

  localparam logic [1:0] BUS_BYTE  = 2'b00;
  localparam logic [1:0] BUS_HALF  = 2'b01;
  localparam logic [1:0] BUS_WORD  = 2'b10;
  localparam logic [1:0] BUS_DWORD = 2'b11;

endpackage

// File: rtl/mp64_icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, two-beat line refill,
// whole/single-line invalidation and free-running hit/miss counters.
module mp64_icache
  import mp64_icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] fetch_addr,
  input  logic        fetch_valid,
  output logic [63:0] fetch_data,
  output logic        fetch_hit,
  output logic        fetch_stall,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [1:0]  bus_size,
  input  logic        inv_all,
  input  logic        inv_line,
  input  logic [63:0] inv_addr,
  output logic [63:0] stat_hits,
  output logic [63:0] stat_misses
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL0 = 2'd1, S_FILL1 = 2'd2} state_t;

  state_t              r_state, w_state_next;
  logic [LINES-1:0]    r_valid, w_valid_next;
  logic [TAG_W-1:0]    r_tag_mem [LINES];
  logic [63:0]         r_lo_mem  [LINES];
  logic [63:0]         r_hi_mem  [LINES];
  logic [59:0]         r_line;
  logic                r_abort;
  logic [63:0]         r_hits, r_misses;

  logic [IDX_W-1:0]    w_idx, w_inv_idx, w_fill_idx;
  logic                w_hit, w_miss, w_fill_done, w_lo_we, w_inv_fill;
  logic                w_unused;

  assign w_idx      = fetch_addr[11:4];
  assign w_inv_idx  = inv_addr[11:4];
  assign w_fill_idx = r_line[IDX_W-1:0];
  assign w_unused   = ^{fetch_addr[2:0], inv_addr[63:12], inv_addr[3:0]};

  assign w_hit = fetch_valid && (r_state == S_IDLE) && r_valid[w_idx] &&
                 (r_tag_mem[w_idx] == fetch_addr[63:12]);
  assign w_miss     = fetch_valid && (r_state == S_IDLE) && !w_hit;
  assign w_inv_fill = inv_all || (inv_line && (w_inv_idx == w_fill_idx));

  assign fetch_hit   = w_hit;
  assign fetch_stall = fetch_valid && !w_hit;
  assign fetch_data  = w_hit ? (fetch_addr[3] ? r_hi_mem[w_idx] : r_lo_mem[w_idx]) : '0;

  assign bus_wen     = 1'b0;
  assign bus_size    = BUS_DWORD;
  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;

  always_comb begin
    w_state_next = r_state;
    bus_valid    = 1'b0;
    bus_addr     = '0;
    w_lo_we      = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) w_state_next = S_FILL0;
      end
      S_FILL0: begin
        bus_valid = 1'b1;
        bus_addr  = {r_line, 4'h0};
        if (bus_ready) begin
          w_lo_we      = 1'b1;
          w_state_next = S_FILL1;
        end
      end
      S_FILL1: begin
        bus_valid = 1'b1;
        bus_addr  = {r_line, 4'h8};
        if (bus_ready) begin
          w_fill_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Invalidation outranks the refill's valid-set on the same edge.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    assign w_valid_next[gi] =
      (inv_all || (inv_line && (w_inv_idx == IDX_W'(gi)))) ? 1'b0 :
      (w_fill_done && !r_abort && (w_fill_idx == IDX_W'(gi))) ? 1'b1 : r_valid[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_line   <= '0;
      r_abort  <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      if (w_hit) r_hits <= r_hits + 64'd1;
      if (w_miss) begin
        r_line   <= fetch_addr[63:4];
        r_misses <= r_misses + 64'd1;
        r_abort  <= inv_all || (inv_line && (w_inv_idx == w_idx));
      end else if (r_state != S_IDLE) begin
        r_abort <= r_abort || w_inv_fill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_lo_we) r_lo_mem[w_fill_idx] <= bus_rdata;
    if (w_fill_done) begin
      r_hi_mem[w_fill_idx]  <= bus_rdata;
      r_tag_mem[w_fill_idx] <= r_line[59:8];
    end
  end

endmodule

// File: tb/tb_mp64_icache.sv
// Self-checking bench for mp64_icache: directed scenarios plus randomized fetch/invalidate traffic
// checked against a line-level model of the cache contents and counters.
module tb_mp64_icache;
  import mp64_icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fetch_addr, fetch_data, bus_addr, bus_rdata, inv_addr, stat_hits, stat_misses;
  logic        fetch_valid, fetch_hit, fetch_stall, bus_valid, bus_ready, bus_wen;
  logic        inv_all, inv_line;
  logic [1:0]  bus_size;

  always #5 clk = ~clk;

  mp64_icache dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_hit(fetch_hit), .fetch_stall(fetch_stall),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_wen(bus_wen), .bus_size(bus_size),
    .inv_all(inv_all), .inv_line(inv_line), .inv_addr(inv_addr),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: which lines are resident, their tags and contents, and the counters.
  logic        m_valid [256];
  logic [51:0] m_tag   [256];
  logic [63:0] m_lo    [256];
  logic [63:0] m_hi    [256];
  logic [63:0] m_hits, m_misses;
  logic [63:0] mem_ovr [logic [63:0]];

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]} + {32'h0, a[63:32]};
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One fetch transaction; on a miss it also serves the two refill beats with random wait states.
  task automatic do_fetch(input logic [63:0] a, input bit inv_in_fill1);
    logic [7:0]  idx;
    logic [51:0] tg;
    logic [63:0] base, exp_d;
    logic        exp_hit;
    bit          abort;
    idx = a[11:4];
    tg  = a[63:12];
    base = {a[63:4], 4'h0};
    fetch_valid = 1'b1;
    fetch_addr  = a;
    #1;
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_d   = exp_hit ? (a[3] ? m_hi[idx] : m_lo[idx]) : 64'h0;
    vectors++;
    if (fetch_hit !== exp_hit || fetch_stall !== !exp_hit || fetch_data !== exp_d) begin
      errors++;
      $display("FAIL fetch a=%h got hit=%b stall=%b data=%h want hit=%b stall=%b data=%h",
               a, fetch_hit, fetch_stall, fetch_data, exp_hit, !exp_hit, exp_d);
    end
    vectors++;
    if (bus_wen !== 1'b0 || bus_size !== BUS_DWORD || bus_valid !== 1'b0 || bus_addr !== 64'h0) begin
      errors++;
      $display("FAIL idle_bus got wen=%b size=%b valid=%b addr=%h want 0 %b 0 0",
               bus_wen, bus_size, bus_valid, bus_addr, BUS_DWORD);
    end
    $display("fetch a=%h hit=%b data=%h", a, fetch_hit, fetch_data);
    if (exp_hit) m_hits++; else m_misses++;
    cyc();
    if (exp_hit) begin
      fetch_valid = 1'b0;
      return;
    end
    abort = 0;
    for (int b = 0; b < 2; b++) begin
      int w;
      w = $urandom_range(0, 3);
      for (int c = 0; c <= w; c++) begin
        fetch_addr = {$urandom, $urandom};
        bus_ready  = (c == w);
        bus_rdata  = bus_ready ? mem_rd(base + 64'(8 * b)) : {$urandom, $urandom};
        inv_all    = inv_in_fill1 && (b == 1) && (c == w);
        #1;
        vectors++;
        if (bus_valid !== 1'b1 || bus_addr !== base + 64'(8 * b) || fetch_hit !== 1'b0 ||
            fetch_stall !== 1'b1 || bus_wen !== 1'b0 || bus_size !== BUS_DWORD) begin
          errors++;
          $display("FAIL refill_beat%0d got valid=%b addr=%h hit=%b stall=%b want 1 %h 0 1",
                   b, bus_valid, bus_addr, fetch_hit, fetch_stall, base + 64'(8 * b));
        end
        if (inv_all) abort = 1;
        cyc();
      end
    end
    bus_ready = 1'b0;
    inv_all = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr = a;
    m_lo[idx] = mem_rd(base);
    m_hi[idx] = mem_rd(base + 64'd8);
    m_tag[idx] = tg;
    if (abort) model_clear_all();
    else m_valid[idx] = 1'b1;
    $display("refill base=%h lo=%h hi=%h aborted=%0d", base, m_lo[idx], m_hi[idx], abort);
  endtask

  task automatic do_inv(input bit all, input bit line, input logic [63:0] a);
    fetch_valid = 1'b0;
    inv_all = all;
    inv_line = line;
    inv_addr = a;
    #1;
    vectors++;
    if (fetch_hit !== 1'b0 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL inv_idle got hit=%b stall=%b want 0 0", fetch_hit, fetch_stall);
    end
    $display("invalidate all=%0d line=%0d addr=%h", all, line, a);
    cyc();
    inv_all = 1'b0;
    inv_line = 1'b0;
    if (all) model_clear_all();
    if (line) m_valid[a[11:4]] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    vectors++;
    if (stat_hits !== 64'h0 || stat_misses !== 64'h0 || bus_valid !== 1'b0 || bus_addr !== 64'h0 ||
        fetch_hit !== 1'b0 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset got hits=%h misses=%h bvalid=%b baddr=%h hit=%b stall=%b want all 0",
               stat_hits, stat_misses, bus_valid, bus_addr, fetch_hit, fetch_stall);
    end
    $display("reset applied");
    rst = 1'b0;
    model_clear_all();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic test_directed();
    do_fetch(64'h100, 0);
    do_fetch(64'h100, 0);
    vectors++;
    if (m_lo[8'h10] !== 64'hAAAA_BBBB_CCCC_DDDD || !m_valid[8'h10]) begin
      errors++;
      $display("FAIL model_line100 got %h want AAAABBBBCCCCDDDD", m_lo[8'h10]);
    end
    do_fetch(64'h108, 0);
    do_fetch(64'h200, 0);
    do_fetch(64'h200, 0);
    do_fetch(64'h100, 0);
  endtask

  task automatic test_invalidate();
    do_inv(0, 1, 64'h100);
    do_fetch(64'h100, 0);
    do_fetch(64'h100, 0);
    do_fetch(64'h200, 0);
    do_inv(1, 0, 64'h0);
    do_fetch(64'h200, 0);
    do_fetch(64'h200, 0);
  endtask

  task automatic test_conflict();
    do_fetch(64'h100, 0);
    do_fetch(64'h1100, 0);
    do_fetch(64'h1100, 0);
    do_fetch(64'h100, 0);
    do_fetch(64'h100, 0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b0;
      fetch_addr = (i == 0) ? 64'h100 : {$urandom, $urandom};
      #1;
      vectors++;
      if (fetch_hit !== 1'b0 || fetch_stall !== 1'b0 || fetch_data !== 64'h0) begin
        errors++;
        $display("FAIL idle got hit=%b stall=%b data=%h want 0 0 0", fetch_hit, fetch_stall, fetch_data);
      end
      $display("idle a=%h hit=%b stall=%b", fetch_addr, fetch_hit, fetch_stall);
      cyc();
    end
  endtask

  task automatic test_inv_during_fill1();
    do_fetch(64'h3000_0040, 1);
    do_fetch(64'h3000_0040, 0);
    do_fetch(64'h3000_0048, 0);
  endtask

  task automatic test_reset_mid_refill();
    do_inv(1, 0, 64'h0);
    fetch_valid = 1'b1;
    fetch_addr = 64'h500;
    cyc();
    fetch_valid = 1'b0;
    #1;
    vectors++;
    if (bus_valid !== 1'b1 || bus_addr !== 64'h500) begin
      errors++;
      $display("FAIL fill0_entry got valid=%b addr=%h want 1 0000000000000500", bus_valid, bus_addr);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus_valid !== 1'b0 || bus_addr !== 64'h0 || stat_misses !== 64'h0 || stat_hits !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b addr=%h hits=%h misses=%h want 0 0 0 0",
               bus_valid, bus_addr, stat_hits, stat_misses);
    end
    $display("reset during FILL0 bus_valid=%b", bus_valid);
    model_clear_all();
    m_hits = 0;
    m_misses = 0;
    do_fetch(64'h500, 0);
    do_fetch(64'h508, 0);
  endtask

  task automatic test_random();
    logic [51:0] tags [4];
    logic [63:0] a;
    tags[0] = 52'h0;
    tags[1] = 52'h1;
    tags[2] = 52'h2;
    tags[3] = 52'hF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 19);
      a = {tags[$urandom_range(0, 3)], 8'($urandom_range(0, 7)), 1'($urandom), 3'($urandom)};
      if (r == 0) do_inv(1, 0, 64'h0);
      else if (r == 1) do_inv(0, 1, a);
      else if (r == 2) do_inv(0, 0, a);
      else do_fetch(a, ($urandom_range(0, 15) == 0));
    end
  endtask

  task automatic test_counters();
    #1;
    vectors++;
    if (stat_hits !== m_hits || stat_misses !== m_misses) begin
      errors++;
      $display("FAIL counters got hits=%0d misses=%0d want %0d %0d", stat_hits, stat_misses, m_hits, m_misses);
    end
    vectors++;
    if (!(stat_hits > 0) || !(stat_misses > 0)) begin
      errors++;
      $display("FAIL counters_nonzero got hits=%0d misses=%0d want both >0", stat_hits, stat_misses);
    end
    $display("counters hits=%0d misses=%0d", stat_hits, stat_misses);
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr = '0;
    bus_rdata = '0;
    bus_ready = 1'b0;
    inv_all = 1'b0;
    inv_line = 1'b0;
    inv_addr = '0;
    mem_ovr[64'h100]  = 64'hAAAA_BBBB_CCCC_DDDD;
    mem_ovr[64'h108]  = 64'h1111_2222_3333_4444;
    mem_ovr[64'h200]  = 64'hDEAD_BEEF_CAFE_BABE;
    mem_ovr[64'h1100] = 64'hBBBB_0000_0000_0001;
    cyc();
    test_reset();
    test_directed();
    test_invalidate();
    test_conflict();
    test_idle();
    test_inv_during_fill1();
    test_reset_mid_refill();
    test_random();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
